spi_reg_ctrl: RTL
=================

// Module: spi_reg_ctrl
// PURPOSE
//  Command/register controller behind the MODE_3 SPI byte slave, in the sysClk domain.
//  Parses each SS frame as a command byte plus data bytes and drives a simple register bus.
//  Addresses auto-increment and wrap. Supplies the next MISO byte (txByte) to the byte core.
//  Turns the byte-level SPI link into a host-accessible register file.
// PARAMETERS
//  NUM_REGS   16     number of registers, 1..128; valid addresses 0..NUM_REGS-1
//  RD_LAT     1      regRdData valid exactly RD_LAT cycles after regRd, 1..4
//  IDLE_BYTE  8'h55  txByte when idle and during the command byte
//  ERR_BYTE   8'hEE  txByte for the rest of a frame with an out-of-range command
// PORTS
//  sysClk       in   1  system clock, 62.5 MHz nominal
//  usrReset     in   1  synchronous reset, active-low (0 = reset)
//  frameActive  in   1  SS asserted, already synchronized to sysClk
//  rxStrobe     in   1  one-cycle pulse: full byte received from MOSI
//  rxByte       in   8  received byte, valid while rxStrobe=1
//  txByte       out  8  byte the core shifts out on the next SPI byte
//  regAddr      out  7  register address
//  regWrData    out  8  write data
//  regWr        out  1  one-cycle write pulse
//  regRd        out  1  one-cycle read pulse
//  regRdData    in   8  read data, valid RD_LAT cycles after regRd
//  busy         out  1  1 while state != IDLE
//  cmdErr       out  1  sticky out-of-range flag, cleared only by reset
// BEHAVIOUR
//  Reset (usrReset=0 at a sysClk edge):
//   - state=IDLE, txByte=IDLE_BYTE, regAddr=0, regWrData=0.
//   - regWr=0, regRd=0, busy=0, cmdErr=0.
//   - Any pending read is discarded; a late regRdData is never captured.
//  Command byte format: bit7 = 1 read / 0 write; bits[6:0] = start address A.
//  States:
//  - IDLE: txByte=IDLE_BYTE. frameActive=1 -> CMD.
//  - CMD, on rxStrobe:
//     - A>=NUM_REGS -> DISCARD; cmdErr<=1; txByte<=ERR_BYTE.
//     - bit7=0 -> WRITE; regAddr<=A.
//     - bit7=1 -> RFETCH; regAddr<=A; regRd=1 on the cycle after the strobe.
//  - WRITE, on rxStrobe:
//     - Cycle after strobe: regWr=1, regWrData=rxByte, txByte<=rxByte (echo).
//     - Next cycle: regAddr<=regAddr+1, wrapping NUM_REGS-1 -> 0.
//  - RFETCH: RD_LAT cycles after regRd, txByte<=regRdData; regAddr<=next (wrapping); -> READ.
//  - READ, on rxStrobe: MOSI byte ignored; -> RFETCH using the current regAddr (prefetch).
//  - DISCARD: every byte ignored; txByte=ERR_BYTE; no regWr, no regRd.
//  Timing guarantee: txByte is final no later than RD_LAT+2 cycles after rxStrobe.
//   The byte core samples txByte at the next SCLK fall, >=125 ns later.
//  Frame end: frameActive=0 in any non-IDLE state -> IDLE on the next cycle; txByte<=IDLE_BYTE.
//   - An in-flight read completes on the bus but its data is dropped.
//   - No regWr is issued for a partial byte; the core never strobes one.
//  rxStrobe and frameActive fall in the same cycle: the byte is processed (a write is still
//   issued), then IDLE.
//  rxStrobe while in RFETCH (a protocol violation): ignored.
//  regWr and regRd are never high in the same cycle; each is at most one cycle per byte.
// TESTING
//  1 Reset: hold usrReset=0 for 3 cycles mid-frame.
//    -> txByte=55, regWr=regRd=busy=cmdErr=0, regAddr=0.
//  2 Write burst: bytes 03,11,22.
//    -> regWr @addr3 data 11, then @addr4 data 22; txByte echoes 11 then 22; cmdErr=0.
//  3 Read wrap (NUM_REGS=16, reg15=AB, reg0=CD): bytes 8F,00,00.
//    -> MISO 55,AB,CD; regRd addresses 15 then 0 then 1.
//  4 Out of range: bytes 20,99 -> cmdErr=1, MISO 55,EE, no regWr.
//    -> cmdErr stays 1 through the next valid frame until reset.
//  5 Abort: command 05, then SS high before any data byte.
//    -> no regWr, busy=0, txByte=55; next frame 86 reads addr6 normally.
//  6 Reset during RFETCH with RD_LAT=3: usrReset=0 one cycle after regRd.
//    -> regRd=0, txByte stays 55, late regRdData ignored.

Source files
------------

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte-link and register-bus bundle for spi_reg_ctrl
//
// Purpose: groups the SPI byte-core handshake and the register bus into one interface.
//   slave  : the controller side (spi_reg_ctrl)
//   master : the byte core plus register file side
// Signals:
//   frameActive  SS asserted, synchronized to sysClk
//   rxStrobe     one-cycle pulse, rxByte valid
//   rxByte[7:0]  received MOSI byte
//   txByte[7:0]  next MISO byte for the byte core
//   regAddr[6:0] register address
//   regWrData    write data
//   regWr/regRd  one-cycle write/read pulses
//   regRdData    read data, valid RD_LAT cycles after regRd
//   busy         controller not idle
//   cmdErr       sticky out-of-range command flag
interface spi_reg_ctrl_if;
   logic       frameActive;
   logic       rxStrobe;
   logic [7:0] rxByte;
   logic [7:0] txByte;
   logic [6:0] regAddr;
   logic [7:0] regWrData;
   logic       regWr;
   logic       regRd;
   logic [7:0] regRdData;
   logic       busy;
   logic       cmdErr;

   modport slave (
      input  frameActive, rxStrobe, rxByte, regRdData,
      output txByte, regAddr, regWrData, regWr, regRd, busy, cmdErr
   );

   modport master (
      output frameActive, rxStrobe, rxByte, regRdData,
      input  txByte, regAddr, regWrData, regWr, regRd, busy, cmdErr
   );
endinterface

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI frame parser driving a simple register bus
//
// Purpose: each SS frame is a command byte (bit7 = read, bits[6:0] = start address)
//   followed by data bytes. Writes echo the data on MISO; reads prefetch the next
//   register so its value is ready before the following byte is shifted. Addresses
//   auto-increment and wrap at NUM_REGS-1. Out-of-range commands set a sticky error
//   and the rest of the frame returns ERR_BYTE.
// Ports:
//   sysClk    system clock
//   usrReset  synchronous reset, active-low
//   bus       spi_reg_ctrl_if.slave (byte link + register bus)
module spi_reg_ctrl #(
   parameter int         NUM_REGS  = 16,
   parameter int         RD_LAT    = 1,
   parameter logic [7:0] IDLE_BYTE = 8'h55,
   parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
   input  logic           sysClk,
   input  logic           usrReset,
   spi_reg_ctrl_if.slave  bus
);

   localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
   localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);
   localparam logic [2:0] RD_LAT_W   = 3'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WRITE,
      RFETCH,
      READ,
      DISCARD
   } state_t;

   state_t     state_q,       state_d;
   logic [7:0] tx_byte_q,     tx_byte_d;
   logic [6:0] reg_addr_q,    reg_addr_d;
   logic [7:0] reg_wr_data_q, reg_wr_data_d;
   logic       reg_wr_q,      reg_wr_d;
   logic       reg_rd_q,      reg_rd_d;
   logic       busy_q,        busy_d;
   logic       cmd_err_q,     cmd_err_d;
   logic       rd_wait_q,     rd_wait_d;
   logic [2:0] rd_cnt_q,      rd_cnt_d;
   logic       rd_done;
   logic       cmd_bad;

   function automatic logic [6:0] next_addr(input logic [6:0] a);
      return (a == LAST_ADDR) ? 7'd0 : a + 7'd1;
   endfunction

   // rd_cnt counts cycles since the regRd pulse; data is on the bus when it reaches RD_LAT.
   assign rd_done = rd_wait_q && !reg_rd_q && (rd_cnt_q == RD_LAT_W);
   assign cmd_bad = ({1'b0, bus.rxByte[6:0]} >= NUM_REGS_W);

   always_comb begin
      state_d       = state_q;
      tx_byte_d     = tx_byte_q;
      reg_addr_d    = reg_addr_q;
      reg_wr_data_d = reg_wr_data_q;
      reg_wr_d      = 1'b0;
      reg_rd_d      = 1'b0;
      cmd_err_d     = cmd_err_q;
      rd_wait_d     = rd_wait_q;
      rd_cnt_d      = rd_cnt_q;

      // The write pulse uses the current address; step it the cycle after.
      if (reg_wr_q) begin
         reg_addr_d = next_addr(reg_addr_q);
      end

      if (reg_rd_q) begin
         rd_wait_d = 1'b1;
         rd_cnt_d  = 3'd1;
      end else if (rd_wait_q && (rd_cnt_q != RD_LAT_W)) begin
         rd_cnt_d = rd_cnt_q + 3'd1;
      end
      if (rd_done) begin
         rd_wait_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            tx_byte_d = IDLE_BYTE;
            if (bus.frameActive) begin
               state_d = CMD;
            end
         end
         CMD: begin
            if (bus.rxStrobe) begin
               if (cmd_bad) begin
                  cmd_err_d = 1'b1;
                  tx_byte_d = ERR_BYTE;
                  state_d   = DISCARD;
               end else if (!bus.rxByte[7]) begin
                  reg_addr_d = bus.rxByte[6:0];
                  state_d    = WRITE;
               end else begin
                  reg_addr_d = bus.rxByte[6:0];
                  // A read whose frame is already closing would be dropped anyway.
                  reg_rd_d   = bus.frameActive;
                  state_d    = RFETCH;
               end
            end
         end
         WRITE: begin
            if (bus.rxStrobe) begin
               reg_wr_d      = 1'b1;
               reg_wr_data_d = bus.rxByte;
               tx_byte_d     = bus.rxByte;
            end
         end
         RFETCH: begin
            // Strobes here are a protocol violation and are ignored.
            if (rd_done) begin
               tx_byte_d  = bus.regRdData;
               reg_addr_d = next_addr(reg_addr_q);
               state_d    = READ;
            end
         end
         READ: begin
            if (bus.rxStrobe) begin
               reg_rd_d = bus.frameActive;
               state_d  = RFETCH;
            end
         end
         DISCARD: begin
            tx_byte_d = ERR_BYTE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Frame end wins over everything except a write already accepted above.
      if ((state_q != IDLE) && !bus.frameActive) begin
         state_d   = IDLE;
         tx_byte_d = IDLE_BYTE;
         rd_wait_d = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sysClk) begin
      if (!usrReset) begin
         state_q       <= IDLE;
         tx_byte_q     <= IDLE_BYTE;
         reg_addr_q    <= 7'd0;
         reg_wr_data_q <= 8'd0;
         reg_wr_q      <= 1'b0;
         reg_rd_q      <= 1'b0;
         busy_q        <= 1'b0;
         cmd_err_q     <= 1'b0;
         rd_wait_q     <= 1'b0;
         rd_cnt_q      <= 3'd0;
      end else begin
         state_q       <= state_d;
         tx_byte_q     <= tx_byte_d;
         reg_addr_q    <= reg_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         reg_wr_q      <= reg_wr_d;
         reg_rd_q      <= reg_rd_d;
         busy_q        <= busy_d;
         cmd_err_q     <= cmd_err_d;
         rd_wait_q     <= rd_wait_d;
         rd_cnt_q      <= rd_cnt_d;
      end
   end

   assign bus.txByte    = tx_byte_q;
   assign bus.regAddr   = reg_addr_q;
   assign bus.regWrData = reg_wr_data_q;
   assign bus.regWr     = reg_wr_q;
   assign bus.regRd     = reg_rd_q;
   assign bus.busy      = busy_q;
   assign bus.cmdErr    = cmd_err_q;

endmodule
